// File: rtl/encoder8x3_rr_if.sv
// Request/result bundle between up to eight requesters, the round-robin
// encoder and its single downstream consumer.
interface encoder8x3_rr_if;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] idx;
    logic [7:0] grant;
    logic       multi;
    logic [7:0] err_cnt;

    // Handshake: a result transfers on a rising edge where out_valid && out_ready.
    // While out_valid=1 and out_ready=0, idx/grant/multi are held stable.
    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output idx,
        output grant,
        output multi,
        output err_cnt
    );

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  idx,
        input  grant,
        input  multi,
        input  err_cnt
    );
endinterface

// File: rtl/encoder8x3_rr.sv
// Round-robin 8-to-3 encoder: registered index/one-hot grant of one active
// request, rotating priority pointer, saturating count of contended loads.
module encoder8x3_rr (
    input  logic                   clk,
    input  logic                   rst,
    encoder8x3_rr_if.slave         bus,
    output logic                   dbg_state_o
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] grant_q, grant_d;
    logic       multi_q, multi_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       load;
    logic       multi_now;
    logic [2:0] sel;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_now = (bus.req & (bus.req - 8'd1)) != 8'd0;
    assign load      = (bus.req != 8'd0) && ((state_q == S_EMPTY) || bus.out_ready);

    // First set request scanning ptr, ptr+1, ... with 3-bit wrap.
    always_comb begin
        logic       found;
        logic [2:0] pos;
        sel   = 3'd0;
        found = 1'b0;
        pos   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            pos = ptr_q + 3'(k);
            if (!found && bus.req[pos]) begin
                found = 1'b1;
                sel   = pos;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        multi_d   = multi_q;
        err_cnt_d = err_cnt_q;
        if (load) begin
            state_d = S_FULL;
            idx_d   = sel;
            grant_d = 8'b1 << sel;
            multi_d = multi_now;
            ptr_d   = sel + 3'd1;
            if (multi_now && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if ((state_q == S_FULL) && bus.out_ready) begin
            state_d = S_EMPTY;
            grant_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            grant_q   <= 8'h00;
            multi_q   <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            multi_q   <= multi_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.out_valid = (state_q == S_FULL);
    assign bus.idx       = idx_q;
    assign bus.grant     = grant_q;
    assign bus.multi     = multi_q;
    assign bus.err_cnt   = err_cnt_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_encoder8x3_rr.sv
// Directed bench for encoder8x3_rr: reset, fairness, wrap, backpressure,
// drain, saturation and mid-operation reset with hand-computed results.
module tb_encoder8x3_rr;
    logic clk;
    logic rst;
    logic dbg_state;

    encoder8x3_rr_if bus ();

    encoder8x3_rr dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [7:0] r, input logic rdy);
        bus.req       = r;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] i,
                             input logic [7:0] g, input logic m);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_idx"},   32'(bus.idx),       32'(i));
        check({tag, "_grant"}, 32'(bus.grant),     32'(g));
        check({tag, "_multi"}, 32'(bus.multi),     32'(m));
    endtask

    initial begin
        logic [7:0] e;
        rst = 1'b1;
        drive(8'h00, 1'b0);

        // Reset state
        do_reset();
        check_out("rst", 1'b0, 3'd0, 8'h00, 1'b0);
        check("rst_err", 32'(bus.err_cnt), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);

        // Single request after reset
        drive(8'h20, 1'b1);
        step();
        check_out("single", 1'b1, 3'd5, 8'h20, 1'b0);
        check("single_err", 32'(bus.err_cnt), 32'h0);
        check("single_state", 32'(dbg_state), 32'h1);

        // Round-robin fairness from reset
        do_reset();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(i % 8));
        drive(8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step();
            e = exp_q.pop_front();
            check($sformatf("rr%0d_idx", i), 32'(bus.idx), 32'(e));
            check($sformatf("rr%0d_grant", i), 32'(bus.grant), 32'(8'b1 << e[2:0]));
            check($sformatf("rr%0d_multi", i), 32'(bus.multi), 32'h1);
            check($sformatf("rr%0d_err", i), 32'(bus.err_cnt), 32'(i + 1));
        end

        // Wrap-around: ptr is 1 after the last idx=0
        drive(8'h40, 1'b1);
        step();
        check("wrap_a_idx", 32'(bus.idx), 32'd6);
        drive(8'h41, 1'b1);
        step();
        check("wrap_b_idx", 32'(bus.idx), 32'd0);
        step();
        check("wrap_c_idx", 32'(bus.idx), 32'd6);
        check("wrap_c_err", 32'(bus.err_cnt), 32'd11);

        // Backpressure: ptr=7, 8'h0C -> idx 2
        drive(8'h0C, 1'b1);
        step();
        check_out("bp_load", 1'b1, 3'd2, 8'h04, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 8'h80 : 8'h0C, 1'b0);
            step();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 3'd2, 8'h04, 1'b1);
        end
        check("bp_err", 32'(bus.err_cnt), 32'd12);
        drive(8'h0C, 1'b1);
        step();
        check_out("bp_next", 1'b1, 3'd3, 8'h08, 1'b1);
        drive(8'h80, 1'b1);
        step();
        check_out("bp_alt", 1'b1, 3'd7, 8'h80, 1'b0);

        // Drain: ptr=0
        drive(8'h01, 1'b1);
        step();
        check_out("drain_load", 1'b1, 3'd0, 8'h01, 1'b0);
        drive(8'h00, 1'b1);
        step();
        check_out("drain_empty", 1'b0, 3'd0, 8'h00, 1'b0);
        check("drain_state", 32'(dbg_state), 32'h0);
        drive(8'h00, 1'b0);
        step();
        check_out("empty_hold", 1'b0, 3'd0, 8'h00, 1'b0);

        // Saturation
        do_reset();
        drive(8'h03, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 254) check("sat_254", 32'(bus.err_cnt), 32'hFE);
            if (i == 255) check("sat_255", 32'(bus.err_cnt), 32'hFF);
            if (i == 300) check("sat_300", 32'(bus.err_cnt), 32'hFF);
        end

        // Reset mid-operation with ready low
        do_reset();
        drive(8'h10, 1'b1);
        step();
        check_out("mid_load", 1'b1, 3'd4, 8'h10, 1'b0);
        drive(8'hFF, 1'b0);
        step();
        check_out("mid_hold", 1'b1, 3'd4, 8'h10, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
        check("mid_rst_err", 32'(bus.err_cnt), 32'h0);
        drive(8'h30, 1'b1);
        step();
        check_out("mid_after", 1'b1, 3'd4, 8'h10, 1'b1);
        check("mid_after_err", 32'(bus.err_cnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
